// File: rtl/morse_char_assembler.sv
// morse_char_assembler
//
// Collects dot/dash pulses from the push-button decoder into a pattern of up
// to five symbols. When GAP_CYCLES cycles pass after the last symbol with no
// further activity, the pattern is translated to ASCII (A-Z, 0-9) and
// presented with a one-cycle CHAR_VALID strobe. Undefined patterns, overflow
// (a sixth symbol) and simultaneous SHORT/LONG produce '?' with ERR.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   SHORT      in   dot pulse, one cycle wide
//   LONG       in   dash pulse, one cycle wide
//   CHAR       out  [7:0] ASCII of the last closed character (held)
//   CHAR_VALID out  one-cycle strobe, CHAR is new
//   ERR        out  one-cycle strobe with CHAR_VALID when CHAR is '?'
//   BUSY       out  a character is being collected
//   LEN        out  [2:0] symbols held in the current character
module morse_char_assembler #(
  parameter int CNT_W      = 28,
  parameter int GAP_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SHORT,
  input  logic       LONG,
  output logic [7:0] CHAR,
  output logic       CHAR_VALID,
  output logic       ERR,
  output logic       BUSY,
  output logic [2:0] LEN
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    BAD     = 2'd2
  } state_t;

  // Terminal count: the character closes on the edge where the counter
  // already holds GAP_CYCLES-1, which puts the strobe GAP_CYCLES edges after
  // the edge that sampled the last symbol.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       QMARK    = 8'h3F;

  state_t           state_q, state_d;
  logic [4:0]       pattern_q, pattern_d;
  logic [2:0]       len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic sym_ev;
  logic bad_sym;
  logic any_act;
  logic timeout;
  logic [8:0] lut;

  // Translate {len, pattern} to {err, ascii}. The first symbol received is
  // the most significant of the len valid bits; dash = 1.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len,
                                              input logic [4:0] pat);
    logic [7:0] c;
    c = QMARK;
    case (len)
      3'd1: c = pat[0] ? 8'h54 : 8'h45;                 // T, E
      3'd2: case (pat[1:0])
              2'b00: c = 8'h49;                         // I
              2'b01: c = 8'h41;                         // A
              2'b10: c = 8'h4E;                         // N
              default: c = 8'h4D;                       // M
            endcase
      3'd3: case (pat[2:0])
              3'b000: c = 8'h53;                        // S
              3'b001: c = 8'h55;                        // U
              3'b010: c = 8'h52;                        // R
              3'b011: c = 8'h57;                        // W
              3'b100: c = 8'h44;                        // D
              3'b101: c = 8'h4B;                        // K
              3'b110: c = 8'h47;                        // G
              default: c = 8'h4F;                       // O
            endcase
      3'd4: case (pat[3:0])
              4'b0000: c = 8'h48;                       // H
              4'b0001: c = 8'h56;                       // V
              4'b0010: c = 8'h46;                       // F
              4'b0100: c = 8'h4C;                       // L
              4'b0110: c = 8'h50;                       // P
              4'b0111: c = 8'h4A;                       // J
              4'b1000: c = 8'h42;                       // B
              4'b1001: c = 8'h58;                       // X
              4'b1010: c = 8'h43;                       // C
              4'b1011: c = 8'h59;                       // Y
              4'b1100: c = 8'h5A;                       // Z
              4'b1101: c = 8'h51;                       // Q
              default: c = QMARK;                       // ..-- .-.- ---. ----
            endcase
      3'd5: case (pat)
              5'b11111: c = 8'h30;
              5'b01111: c = 8'h31;
              5'b00111: c = 8'h32;
              5'b00011: c = 8'h33;
              5'b00001: c = 8'h34;
              5'b00000: c = 8'h35;
              5'b10000: c = 8'h36;
              5'b11000: c = 8'h37;
              5'b11100: c = 8'h38;
              5'b11110: c = 8'h39;
              default:  c = QMARK;
            endcase
      default: c = QMARK;
    endcase
    return {(c == QMARK), c};
  endfunction

  assign sym_ev  = SHORT ^ LONG;
  assign bad_sym = SHORT & LONG;
  assign any_act = SHORT | LONG;
  assign timeout = (cnt_q == GAP_LAST);
  assign lut     = morse_lookup(len_q, pattern_q);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    char_d    = char_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sym_ev) begin
          pattern_d = {4'b0000, LONG};
          len_d     = 3'd1;
          state_d   = COLLECT;
        end else if (bad_sym) begin
          len_d   = 3'd0;
          state_d = BAD;
        end
      end

      COLLECT: begin
        if (bad_sym) begin
          cnt_d   = '0;
          state_d = BAD;
        end else if (sym_ev) begin
          cnt_d = '0;
          if (len_q == 3'd5) begin
            state_d = BAD;
          end else begin
            pattern_d = {pattern_q[3:0], LONG};
            len_d     = len_q + 3'd1;
          end
        end else if (timeout) begin
          char_d    = lut[7:0];
          err_d     = lut[8];
          valid_d   = 1'b1;
          pattern_d = '0;
          len_d     = 3'd0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BAD: begin
        // Activity only keeps the character open; its content is already lost.
        if (any_act) begin
          cnt_d = '0;
        end else if (timeout) begin
          char_d    = QMARK;
          err_d     = 1'b1;
          valid_d   = 1'b1;
          pattern_d = '0;
          len_d     = 3'd0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        pattern_d = '0;
        len_d     = 3'd0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= 3'd0;
      cnt_q     <= '0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign CHAR       = char_q;
  assign CHAR_VALID = valid_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != IDLE);
  assign LEN        = len_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Testbench for morse_char_assembler with GAP_CYCLES = 16.
// A string-based Morse model runs alongside the DUT and is compared on every
// falling edge; directed scenarios add literal expectations.
module tb_morse_char_assembler;

  localparam int GAP = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SHORT = 1'b0;
  logic       LONG = 1'b0;
  logic [7:0] CHAR;
  logic       CHAR_VALID;
  logic       ERR;
  logic       BUSY;
  logic [2:0] LEN;

  morse_char_assembler #(.CNT_W(28), .GAP_CYCLES(GAP)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SHORT      (SHORT),
    .LONG       (LONG),
    .CHAR       (CHAR),
    .CHAR_VALID (CHAR_VALID),
    .ERR        (ERR),
    .BUSY       (BUSY),
    .LEN        (LEN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_pulse = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

  function automatic logic [8:0] m_lookup(input string code, input bit bad);
    if (bad) return {1'b1, 8'h3F};
    for (int i = 0; i < 36; i++)
      if (codes[i] == code)
        return (i < 26) ? {1'b0, 8'(65 + i)} : {1'b0, 8'(48 + i - 26)};
    return {1'b1, 8'h3F};
  endfunction

  bit         m_active, m_bad, m_valid, m_err;
  int         m_len, m_t, m_last;
  string      m_code;
  logic [7:0] m_char;
  logic [8:0] m_res;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_active = 0; m_bad = 0; m_valid = 0; m_err = 0;
      m_len = 0; m_t = 0; m_last = 0; m_code = ""; m_char = 8'h00;
    end else begin
      m_t++;
      m_valid = 0;
      m_err = 0;
      if (SHORT || LONG) begin
        if (!m_active) begin
          m_active = 1; m_bad = 0; m_len = 0; m_code = "";
        end
        if (SHORT && LONG) m_bad = 1;
        else if (!m_bad) begin
          if (m_len == 5) m_bad = 1;
          else begin
            m_code = {m_code, (LONG ? "-" : ".")};
            m_len++;
          end
        end
        m_last = m_t;
      end else if (m_active && (m_t - m_last == GAP)) begin
        m_res = m_lookup(m_code, m_bad);
        m_char = m_res[7:0];
        m_err = m_res[8];
        m_valid = 1;
        m_active = 0;
        m_len = 0;
        m_code = "";
      end
    end
  end

  // ---------------- every-cycle comparison ----------------
  always @(negedge CLK) begin
    check("model_char", CHAR, m_char);
    check("model_valid", CHAR_VALID, m_valid);
    check("model_err", ERR, m_err);
    check("model_busy", BUSY, m_active);
    check("model_len", LEN, m_len);
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse(input bit s, input bit l);
    SHORT = s;
    LONG = l;
    @(negedge CLK);
    SHORT = 1'b0;
    LONG = 1'b0;
    last_pulse = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_char(input string name, input int c, input int e);
    int n = 0;
    while (!CHAR_VALID && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_strobe"}, CHAR_VALID, 1);
    check({name, "_latency"}, cyc - last_pulse, GAP);
    check({name, "_char"}, CHAR, c);
    check({name, "_err"}, ERR, e);
    check({name, "_busy_low"}, BUSY, 0);
    @(negedge CLK);
    check({name, "_one_cycle"}, CHAR_VALID, 0);
    check({name, "_char_hold"}, CHAR, c);
  endtask

  task automatic seq(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      pulse(pat[i] == ".", pat[i] == "-");
      if (i < pat.len() - 1) idle(3);
    end
  endtask

  initial begin
    int strobes;
    #1 RESET = 1'b1;
    idle(2);
    check("reset_char", CHAR, 0);
    check("reset_valid", CHAR_VALID, 0);
    check("reset_len", LEN, 0);
    check("reset_busy", BUSY, 0);
    RESET = 1'b0;
    idle(2);

    // single dot -> E
    pulse(1, 0);
    check("e_busy", BUSY, 1);
    check("e_len", LEN, 1);
    expect_char("E", 8'h45, 0);
    idle(2);

    // SOS with LEN tracking
    for (int g = 0; g < 3; g++) begin
      for (int k = 1; k <= 3; k++) begin
        pulse(g == 1 ? 0 : 1, g == 1 ? 1 : 0);
        check("sos_len", LEN, k);
        if (k < 3) idle(3);
      end
      expect_char(g == 1 ? "O" : "S", g == 1 ? 8'h4F : 8'h53, 0);
      idle(1);
    end

    seq("-----"); expect_char("zero", 8'h30, 0); idle(1);
    seq("....."); expect_char("five", 8'h35, 0); idle(1);
    seq(".-.");   expect_char("R", 8'h52, 0);    idle(1);
    seq("..--");  expect_char("undef4", 8'h3F, 1); idle(1);
    seq("......"); check("ovf_len", LEN, 5);
    expect_char("overflow", 8'h3F, 1); idle(1);

    // both pulses together in IDLE
    pulse(1, 1);
    check("both_len", LEN, 0);
    check("both_busy", BUSY, 1);
    expect_char("both", 8'h3F, 1);
    idle(1);

    // symbol exactly in the timeout cycle keeps the character open
    pulse(1, 0);
    idle(GAP - 1);
    pulse(1, 0);
    check("tmo_valid", CHAR_VALID, 0);
    check("tmo_len", LEN, 2);
    expect_char("I", 8'h49, 0);
    idle(1);

    // reset in the middle of a character
    seq("-.-");
    idle(2);
    #1 RESET = 1'b1;
    #1;
    check("rst_char", CHAR, 0);
    check("rst_len", LEN, 0);
    check("rst_busy", BUSY, 0);
    check("rst_valid", CHAR_VALID, 0);
    @(negedge CLK);
    RESET = 1'b0;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (CHAR_VALID) strobes++;
    end
    check("rst_no_emit", strobes, 0);
    pulse(0, 1);
    expect_char("T", 8'h54, 0);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
